logic_fn_pipe: RTL and testbench

LOGIC_FN_PIPE -- requirements
Module: logic_fn_pipe

---
 rtl/logic_fn_pkg.sv | 30 +++
 rtl/logic_fn_pipe_popcount.sv | 17 +
 rtl/logic_fn_pipe.sv | 74 +++++++
 tb/tb_logic_fn_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_fn_pkg.sv
// Shared mode encodings and the per-bit logic function used by logic_fn_pipe.
package logic_fn_pkg;

    localparam logic [1:0] MODE_NSEL = 2'd0;
    localparam logic [1:0] MODE_SEL  = 2'd1;
    localparam logic [1:0] MODE_PAR  = 2'd2;
    localparam logic [1:0] MODE_MAJ  = 2'd3;

    localparam int MAX_W = 64;

    // Evaluated at full 64-bit width; callers zero-extend operands and keep the low bits.
    function automatic logic [MAX_W-1:0] logic_fn(
        input logic [1:0]       mode,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] c
    );
        logic [MAX_W-1:0] sel;
        logic [MAX_W-1:0] res;
        sel = (a & b) | (~b & c);
        case (mode)
            MODE_NSEL: res = ~sel;
            MODE_SEL:  res = sel;
            MODE_PAR:  res = a ^ b ^ c;
            default:   res = (a & b) | (a & c) | (b & c);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_fn_pipe_popcount.sv
// Combinational ones-count of a WIDTH-bit vector; result spans 0..WIDTH.
module popcount #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/logic_fn_pipe.sv
// Two-stage elastic pipeline: stage 1 registers the selected logic function,
// stage 2 registers the result together with its ones-count.
module logic_fn_pipe
    import logic_fn_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] f,
    output logic [CW-1:0]    ones,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [MAX_W-1:0] fn_full_p0;
    logic [WIDTH-1:0] fn_p0;
    logic [WIDTH-1:0] fn_p1;
    logic [CW-1:0]    cnt_p1;
    logic             s1_valid;
    logic             ld_p1;
    logic             ld_p2;

    // An empty stage always loads, so bubbles collapse regardless of out_ready.
    assign ld_p2    = !out_valid || out_ready;
    assign ld_p1    = !s1_valid || ld_p2;
    assign in_ready = ld_p1;

    assign fn_full_p0 = logic_fn(mode, MAX_W'(a), MAX_W'(b), MAX_W'(c));
    assign fn_p0      = fn_full_p0[WIDTH-1:0];

    // Stage 0 -> 1: function result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (ld_p1) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p1 && in_valid) begin
            fn_p1 <= fn_p0;
        end
    end

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .vec (fn_p1),
        .cnt (cnt_p1)
    );

    // Stage 1 -> 2: result and ones-count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            ones      <= '0;
        end else if (ld_p2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                f    <= fn_p1;
                ones <= cnt_p1;
            end
        end
    end

endmodule

// File: tb/tb_logic_fn_pipe.sv
// Scoreboard bench for logic_fn_pipe (WIDTH=8): directed patterns, stall, async reset, random traffic.
module tb_logic_fn_pipe;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a, b, c;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  f;
    logic [CW-1:0] ones;
    logic          out_valid;
    logic          out_ready;

    logic_fn_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .ones      (ones),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  f;
        logic [CW-1:0] ones;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [W-1:0]  recv_f[$];
    logic [CW-1:0] recv_o[$];
    int            recv_lat[$];
    int            total = 0;
    int            bad   = 0;
    int            ncyc  = 0;
    int            n_in  = 0;
    int            n_out = 0;

    // Reference: per-bit truth rules, ones by counting.
    function automatic logic [W-1:0] ref_fn(input logic [1:0] m, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic [W-1:0] z);
        logic [W-1:0] r;
        int s;
        for (int i = 0; i < W; i++) begin
            s = int'(x[i]) + int'(y[i]) + int'(z[i]);
            case (m)
                2'd0:    r[i] = y[i] ? ~x[i] : ~z[i];
                2'd1:    r[i] = y[i] ? x[i] : z[i];
                2'd2:    r[i] = (s % 2) == 1;
                default: r[i] = s >= 2;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: both handshakes are sampled on the falling edge, ahead of the rising edge that completes them.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 64'(f), 64'hx);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_f", 64'(f), 64'(e.f));
                    chk("sb_ones", 64'(ones), 64'(e.ones));
                    recv_f.push_back(f);
                    recv_o.push_back(ones);
                    recv_lat.push_back(ncyc - e.cyc);
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                e.f    = ref_fn(mode, a, b, c);
                e.ones = CW'(ref_ones(e.f));
                e.cyc  = ncyc;
                sbq.push_back(e);
            end
        end
    end

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                         input logic [1:0] m);
        @(posedge clk);
        #1;
        a = x; b = y; c = z; mode = m; in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    logic [W-1:0] dir_f[4]    = '{8'h1D, 8'hE2, 8'h96, 8'hE8};
    logic [W-1:0] stall_exp[$];
    logic [W-1:0] hold_f;
    int           base, n0, issued, cyc, nout0, n_in0, n_out0, waitc;
    logic [W-1:0] ra, rb, rc;
    logic [1:0]   rm;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; mode = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_f", 64'(f), 64'd0);
        chk("rst_ones", 64'(ones), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed: one beat per mode on consecutive cycles.
        base = recv_f.size();
        for (int m = 0; m < 4; m++) drive(8'hF0, 8'hCC, 8'hAA, 2'(m));
        idle(5);
        chk("dir_count", 64'(recv_f.size() - base), 64'd4);
        if (recv_f.size() - base >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("dir_f%0d", k), 64'(recv_f[base+k]), 64'(dir_f[k]));
                chk($sformatf("dir_ones%0d", k), 64'(recv_o[base+k]), 64'd4);
                chk($sformatf("dir_lat%0d", k), 64'(recv_lat[base+k]), 64'd2);
            end
        end

        // Boundary: all-ones and all-zeros results.
        base = recv_f.size();
        drive(8'hFF, 8'hFF, 8'h00, 2'd1);
        drive(8'hFF, 8'hFF, 8'h00, 2'd0);
        idle(4);
        chk("bnd_count", 64'(recv_f.size() - base), 64'd2);
        if (recv_f.size() - base >= 2) begin
            chk("bnd_f_ff", 64'(recv_f[base]), 64'hFF);
            chk("bnd_ones_8", 64'(recv_o[base]), 64'd8);
            chk("bnd_f_00", 64'(recv_f[base+1]), 64'h00);
            chk("bnd_ones_0", 64'(recv_o[base+1]), 64'd0);
        end

        // Stall: 10 streamed beats, out_ready low for 3 cycles mid-stream.
        base = recv_f.size();
        n0 = n_in; issued = 0; cyc = 0;
        stall_exp.delete();
        while ((recv_f.size() - base < 10) && cyc < 60) begin
            @(posedge clk);
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_f_hold", 64'(f), 64'(hold_f));
                chk("stall_out_valid", 64'(out_valid), 64'd1);
            end
            if (cyc == 4) begin
                out_ready = 1'b0;
                hold_f = f;
            end
            if (cyc == 7) out_ready = 1'b1;
            if ((n_in - n0) == issued && issued < 10) begin
                ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rm = 2'($urandom);
                a = ra; b = rb; c = rc; mode = rm; in_valid = 1'b1;
                stall_exp.push_back(ref_fn(rm, ra, rb, rc));
                issued++;
            end else if ((n_in - n0) == issued) begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("stall_count", 64'(recv_f.size() - base), 64'd10);
        if (recv_f.size() - base >= 10) begin
            for (int k = 0; k < 10; k++) chk($sformatf("stall_order%0d", k), 64'(recv_f[base+k]), 64'(stall_exp[k]));
        end

        // Async reset with two beats in flight.
        drive(8'h12, 8'h34, 8'h56, 2'd2);
        drive(8'h9A, 8'hBC, 8'hDE, 2'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_f", 64'(f), 64'd0);
        chk("arst_ones", 64'(ones), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        nout0 = n_out;
        idle(6);
        chk("arst_no_stale", 64'(n_out - nout0), 64'd0);
        chk("arst_out_valid_after", 64'(out_valid), 64'd0);

        // Random traffic.
        n_in0 = n_in; n_out0 = n_out;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            a = W'($urandom); b = W'($urandom); c = W'($urandom); mode = 2'($urandom);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        waitc = 0;
        while (sbq.size() != 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        #1;
        chk("rand_drained", 64'(sbq.size()), 64'd0);
        chk("rand_beats_balance", 64'(n_in - n_in0), 64'(n_out - n_out0));
        chk("rand_some_traffic", 64'((n_in - n_in0) > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
